// File: rtl/reg_arb_pkg.sv
// Shared types and default widths for the round-robin register write arbiter.
package reg_arb_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/register bus of the write arbiter: requests and data in, grant/ack and register drive out.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = DATA_W
);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic                   reg_en;
    logic [WIDTH-1:0]       reg_d;
    logic [CNT_W-1:0]       wr_cnt;

    modport master (
        output req, wdata, lock,
        input  gnt, ack, reg_en, reg_d, wr_cnt
    );

    modport slave (
        input  req, wdata, lock,
        output gnt, ack, reg_en, reg_d, wr_cnt
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        rot   = N_REQ'({req, req} >> ptr);
        off   = '0;
        // Scan downward so the lowest set offset from ptr wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
        idx   = sum[IDX_W-1:0];
        valid = |req;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter driving one shared enabled register, one write per grant.
// Define ARB_LOCK_EN to let a granted requester hold lock for back-to-back burst writes.
//
// state | meaning
// IDLE  | no grant; pick the next winner from ptr when any req is high
// WRITE | gnt_idx owns the register; write happens when its req is still high
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = DATA_W,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input logic              clk,
    input logic              reset,
    reg_write_arbiter_if.slave bus
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] gnt_idx, gnt_idx_nxt;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_nxt;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             cur_req;
    logic             hold;
    logic             wr_active;
    logic [IDX_W-1:0] ptr_inc;
    logic [N_REQ-1:0] idx_oh;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign cur_req = bus.req[gnt_idx];
    assign ptr_inc = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef ARB_LOCK_EN
    assign hold = bus.lock[gnt_idx];
`else
    logic unused_lock;
    assign hold        = 1'b0;
    assign unused_lock = ^bus.lock;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            wr_cnt_q <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt_idx  <= gnt_idx_nxt;
            wr_cnt_q <= wr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_idx_nxt = gnt_idx;
        wr_cnt_nxt  = wr_cnt_q;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_idx_nxt = pick_idx;
                    state_nxt   = WRITE;
                end
            end
            WRITE: begin
                if (cur_req) begin
                    wr_cnt_nxt = wr_cnt_q + 1'b1;
                    // A locked burst keeps the grant and leaves ptr where it was.
                    if (!hold) begin
                        ptr_nxt   = ptr_inc;
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_active  = (state == WRITE);
    assign idx_oh     = N_REQ'(1) << gnt_idx;
    assign bus.gnt    = wr_active ? idx_oh : '0;
    assign bus.ack    = (wr_active && cur_req) ? idx_oh : '0;
    assign bus.reg_en = wr_active & cur_req;
    assign bus.reg_d  = wr_active ? bus.wdata[gnt_idx*WIDTH +: WIDTH] : '0;
    assign bus.wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a transaction-level model compared every falling edge.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wd [4];
    int          n_chk = 0;
    int          n_err = 0;
    bit          run = 1'b0;
    int          order [$];
    int          exp_order [5] = '{0, 1, 2, 3, 0};

`ifdef ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    reg_write_arbiter_if #(.N_REQ(4), .WIDTH(32)) bus ();

    assign bus.wdata = {wd[3], wd[2], wd[1], wd[0]};

    reg_write_arbiter #(.N_REQ(4), .WIDTH(32), .IDX_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: who owns the register, where the rotation resumes, how many writes landed.
    bit m_busy = 1'b0;
    int m_who  = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_who  <= 0;
            m_ptr  <= 0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (pick(bus.req, m_ptr) >= 0) begin
                m_busy <= 1'b1;
                m_who  <= pick(bus.req, m_ptr);
            end
        end else if (bus.req[m_who]) begin
            m_cnt <= (m_cnt + 1) % 256;
            if (!(LOCK_ON && bus.lock[m_who])) begin
                m_busy <= 1'b0;
                m_ptr  <= (m_who + 1) % 4;
            end
        end else begin
            m_busy <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("m_gnt", 32'(bus.gnt), m_busy ? (32'd1 << m_who) : 32'd0);
            chk("m_ack", 32'(bus.ack), (m_busy && bus.req[m_who]) ? (32'd1 << m_who) : 32'd0);
            chk("m_reg_en", 32'(bus.reg_en), (m_busy && bus.req[m_who]) ? 32'd1 : 32'd0);
            chk("m_reg_d", bus.reg_d, m_busy ? wd[m_who] : 32'd0);
            chk("m_wr_cnt", 32'(bus.wr_cnt), 32'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        bus.req  = 4'b1111;
        bus.lock = 4'b0000;
        for (int i = 0; i < 4; i++) wd[i] = 32'(100 + i);

        // Reset held with all requests pending
        cyc();
        run = 1'b1;
        cyc();
        cyc();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_reg_en", 32'(bus.reg_en), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_wr_cnt", 32'(bus.wr_cnt), 32'd0);

        // Rotation with every requester asking continuously
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (c == 0) chk("first_gnt", 32'(bus.gnt), 32'b0001);
            for (int i = 0; i < 4; i++) if (bus.ack[i]) order.push_back(i);
        end
        chk("rr_wr_cnt", 32'(bus.wr_cnt), 32'd5);
        chk("rr_len", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
        end

        // Reset while requester 1 is in its write cycle
        cyc();
        chk("pre_rst_gnt", 32'(bus.gnt), 32'b0010);
        #2 reset = 1'b0;
        #1;
        chk("midrst_gnt", 32'(bus.gnt), 32'd0);
        chk("midrst_reg_en", 32'(bus.reg_en), 32'd0);
        chk("midrst_ack", 32'(bus.ack), 32'd0);
        chk("midrst_wr_cnt", 32'(bus.wr_cnt), 32'd0);
        bus.req = 4'b0000;
        cyc();
        reset = 1'b1;

        // Withdrawal: requester 1 drops req inside its write cycle
        bus.req = 4'b0010;
        cyc();
        chk("wd_gnt", 32'(bus.gnt), 32'b0010);
        bus.req = 4'b0000;
        #1;
        chk("wd_reg_en", 32'(bus.reg_en), 32'd0);
        chk("wd_ack", 32'(bus.ack), 32'd0);
        cyc();
        chk("wd_wr_cnt", 32'(bus.wr_cnt), 32'd0);
        chk("wd_gnt_clr", 32'(bus.gnt), 32'd0);
        // ptr still 0, so requester 1 beats requester 2
        bus.req = 4'b0110;
        cyc();
        chk("wd_regrant", 32'(bus.gnt), 32'b0010);
        cyc();
        bus.req = 4'b0000;
        chk("wd_done_cnt", 32'(bus.wr_cnt), 32'd1);

        // Single request from requester 2
        wd[2]   = 32'd94;
        bus.req = 4'b0100;
        cyc();
        chk("one_gnt", 32'(bus.gnt), 32'b0100);
        chk("one_reg_en", 32'(bus.reg_en), 32'd1);
        chk("one_reg_d", bus.reg_d, 32'd94);
        chk("one_ack", 32'(bus.ack), 32'b0100);
        cyc();
        chk("one_ack_end", 32'(bus.ack), 32'd0);
        chk("one_wr_cnt", 32'(bus.wr_cnt), 32'd2);
        bus.req = 4'b0000;

        // Requester 3 asserts lock while requester 0 also waits; ptr is 3
        wd[3]    = 32'd5;
        bus.req  = 4'b1001;
        bus.lock = 4'b1000;
`ifdef ARB_LOCK_EN
        cyc();
        chk("lk_gnt_a", 32'(bus.gnt), 32'b1000);
        chk("lk_d_5", bus.reg_d, 32'd5);
        chk("lk_en_a", 32'(bus.reg_en), 32'd1);
        cyc();
        wd[3] = 32'd6;
        #1;
        chk("lk_gnt_b", 32'(bus.gnt), 32'b1000);
        chk("lk_d_6", bus.reg_d, 32'd6);
        chk("lk_en_b", 32'(bus.reg_en), 32'd1);
        chk("lk_cnt_b", 32'(bus.wr_cnt), 32'd3);
        cyc();
        wd[3]    = 32'd7;
        bus.lock = 4'b0000;
        #1;
        chk("lk_d_7", bus.reg_d, 32'd7);
        chk("lk_en_c", 32'(bus.reg_en), 32'd1);
        chk("lk_cnt_c", 32'(bus.wr_cnt), 32'd4);
        cyc();
        bus.req = 4'b0001;
        chk("lk_release", 32'(bus.gnt), 32'd0);
        chk("lk_cnt_d", 32'(bus.wr_cnt), 32'd5);
        cyc();
        chk("lk_next_gnt", 32'(bus.gnt), 32'b0001);
        chk("lk_next_d", bus.reg_d, 32'd100);
        cyc();
        bus.req = 4'b0000;
        chk("lk_final_cnt", 32'(bus.wr_cnt), 32'd6);
`else
        cyc();
        chk("nl_gnt", 32'(bus.gnt), 32'b1000);
        chk("nl_d_5", bus.reg_d, 32'd5);
        cyc();
        chk("nl_lock_ignored", 32'(bus.gnt), 32'd0);
        chk("nl_cnt", 32'(bus.wr_cnt), 32'd3);
        cyc();
        chk("nl_wrap_gnt", 32'(bus.gnt), 32'b0001);
        cyc();
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        chk("nl_final_cnt", 32'(bus.wr_cnt), 32'd4);
`endif

        // 256 further writes bring the counter back around to the same value
        bus.req = 4'b1111;
        repeat (512) cyc();
        bus.req = 4'b0000;
        chk("wrap_cnt", 32'(bus.wr_cnt), LOCK_ON ? 32'd6 : 32'd4);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
